p5_video_sync_irq: RTL and testbench

- Consumes the 9-bit absolute H/V counters from the video timing generator on the same 6 MHz pixel enable.
- Produces registered composite-timing outputs (HSYNC, VSYNC, HBLANK, VBLANK) for the video output and scan-out stages.
- Produces the main Z80 interrupt request with its RST vector byte, using a per-source pending/acknowledge handshake.
- Sits directly downstream of the counter block; feeds the video DAC/scaler path and the CPU interrupt input.

---
 rtl/p5_video_sync_irq_if.sv | 28 ++
 rtl/p5_video_sync_irq.sv | 112 +++++++++++
 tb/tb_p5_video_sync_irq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/p5_video_sync_irq_if.sv
`default_nettype none
// ============================================================================
// Module   : p5_video_sync_irq_if
// Brief    : Z80 interrupt request / acknowledge bundle for the video IRQ block.
// Revision : 1.0
// ============================================================================
interface p5_video_sync_irq_if;
   logic       IRQ_EN;
   logic       INTACK;
   logic       IRQ_n;
   logic [7:0] IRQ_VECTOR;

   // CPU side: owns the enable latch and the acknowledge strobe
   modport master (
      output IRQ_EN,
      output INTACK,
      input  IRQ_n,
      input  IRQ_VECTOR
   );

   modport slave (
      input  IRQ_EN,
      input  INTACK,
      output IRQ_n,
      output IRQ_VECTOR
   );
endinterface
`default_nettype wire

// File: rtl/p5_video_sync_irq.sv
`default_nettype none
// ============================================================================
// Module   : p5_video_sync_irq
// Brief    : Registered sync/blank decode plus LINE/VBL interrupt with vector.
// Revision : 1.0
// ============================================================================
module p5_video_sync_irq #(
   parameter logic [8:0] HS_START   = 9'd292,
   parameter logic [8:0] HS_END     = 9'd323,
   parameter logic [8:0] VS_START   = 9'd500,
   parameter logic [8:0] VS_END     = 9'd503,
   parameter logic [8:0] VACT_START = 9'd272,
   parameter logic [8:0] VACT_END   = 9'd495,
   parameter logic [8:0] IRQ_H      = 9'd128,
   parameter logic [7:0] VEC_LINE   = 8'hCF,
   parameter logic [7:0] VEC_VBL    = 8'hD7
) (
   input  wire logic           i_EMU_MCLK,
   input  wire logic           i_EMU_RST,
   input  wire logic           i_EMU_CLK6MPCEN_n,
   input  wire logic [8:0]     i_ABS_H_CNTR,
   input  wire logic [8:0]     i_ABS_V_CNTR,
   p5_video_sync_irq_if.slave  irq_if,
   output logic                o_HSYNC_n,
   output logic                o_VSYNC_n,
   output logic                o_HBLANK_n,
   output logic                o_VBLANK_n
);

   localparam logic [8:0] c_VBL_LINE = VACT_END + 9'd1;
   localparam logic [7:0] c_VEC_NONE = 8'hFF;

   logic       r_hsync_n, r_vsync_n, r_hblank_n, r_vblank_n;
   logic       r_pend_line, r_pend_vbl;
   logic       r_irq_n;
   logic [7:0] r_vector;
   logic [1:0] r_src;            // {vbl, line}: source currently on the vector bus

   logic       w_tick;
   logic       w_line_evt, w_vbl_evt;
   logic       w_clr_line, w_clr_vbl;
   logic       w_pend_line_nx, w_pend_vbl_nx;
   logic [7:0] w_vector_nx;
   logic [1:0] w_src_nx;

   assign w_tick = ~i_EMU_CLK6MPCEN_n;

   always_comb begin
      w_line_evt = 1'b0;
      w_vbl_evt  = 1'b0;
      if (w_tick && irq_if.IRQ_EN && (i_ABS_H_CNTR == IRQ_H)) begin
         w_line_evt = (i_ABS_V_CNTR == VACT_START);
         w_vbl_evt  = (i_ABS_V_CNTR == c_VBL_LINE);
      end

      // Clear targets the registered presented source, so a same-edge change cannot misdirect it
      w_clr_line = irq_if.INTACK & r_src[0];
      w_clr_vbl  = irq_if.INTACK & r_src[1];

      w_pend_line_nx = irq_if.IRQ_EN & (w_line_evt | (r_pend_line & ~w_clr_line));
      w_pend_vbl_nx  = irq_if.IRQ_EN & (w_vbl_evt  | (r_pend_vbl  & ~w_clr_vbl));

      w_vector_nx = c_VEC_NONE;
      w_src_nx    = 2'b00;
      if (w_pend_vbl_nx) begin
         w_vector_nx = VEC_VBL;
         w_src_nx    = 2'b10;
      end else if (w_pend_line_nx) begin
         w_vector_nx = VEC_LINE;
         w_src_nx    = 2'b01;
      end
   end

   always_ff @(posedge i_EMU_MCLK) begin
      if (i_EMU_RST) begin
         r_hsync_n  <= 1'b1;
         r_vsync_n  <= 1'b1;
         r_hblank_n <= 1'b0;
         r_vblank_n <= 1'b0;
      end else if (w_tick) begin
         r_hsync_n  <= ~((i_ABS_H_CNTR >= HS_START) && (i_ABS_H_CNTR <= HS_END));
         r_vsync_n  <= ~((i_ABS_V_CNTR >= VS_START) && (i_ABS_V_CNTR <= VS_END));
         r_hblank_n <= i_ABS_H_CNTR[8];
         r_vblank_n <= ~((i_ABS_V_CNTR < VACT_START) || (i_ABS_V_CNTR > VACT_END));
      end
   end

   always_ff @(posedge i_EMU_MCLK) begin
      if (i_EMU_RST) begin
         r_pend_line <= 1'b0;
         r_pend_vbl  <= 1'b0;
         r_irq_n     <= 1'b1;
         r_vector    <= c_VEC_NONE;
         r_src       <= 2'b00;
      end else begin
         r_pend_line <= w_pend_line_nx;
         r_pend_vbl  <= w_pend_vbl_nx;
         r_irq_n     <= ~(w_pend_line_nx | w_pend_vbl_nx);
         r_vector    <= w_vector_nx;
         r_src       <= w_src_nx;
      end
   end

   assign o_HSYNC_n         = r_hsync_n;
   assign o_VSYNC_n         = r_vsync_n;
   assign o_HBLANK_n        = r_hblank_n;
   assign o_VBLANK_n        = r_vblank_n;
   assign irq_if.IRQ_n      = r_irq_n;
   assign irq_if.IRQ_VECTOR = r_vector;

endmodule
`default_nettype wire

// File: tb/tb_p5_video_sync_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_p5_video_sync_irq
// Brief    : Directed self-checking bench for p5_video_sync_irq.
// Revision : 1.0
// ============================================================================
module tb_p5_video_sync_irq;

   logic       clk;
   logic       rst;
   logic       cen_n;
   logic [8:0] h_cnt;
   logic [8:0] v_cnt;
   logic       hsync_n, vsync_n, hblank_n, vblank_n;

   int n_cmp;
   int n_err;

   p5_video_sync_irq_if irq_bus ();

   p5_video_sync_irq dut (
      .i_EMU_MCLK        (clk),
      .i_EMU_RST         (rst),
      .i_EMU_CLK6MPCEN_n (cen_n),
      .i_ABS_H_CNTR      (h_cnt),
      .i_ABS_V_CNTR      (v_cnt),
      .irq_if            (irq_bus.slave),
      .o_HSYNC_n         (hsync_n),
      .o_VSYNC_n         (vsync_n),
      .o_HBLANK_n        (hblank_n),
      .o_VBLANK_n        (vblank_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_cmp++;
      if (obs !== req) begin
         n_err++;
         $display("FAIL %s: observed %0h required %0h", tag, obs, req);
      end
   endtask

   // One enabled pixel tick with the given counters; outputs sampled 1ns after the edge
   task automatic tick(input logic [8:0] h, input logic [8:0] v);
      h_cnt = h;
      v_cnt = v;
      cen_n = 1'b0;
      @(posedge clk);
      #1;
      cen_n = 1'b1;
   endtask

   task automatic idle_mclk(input int n);
      cen_n = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ack();
      irq_bus.INTACK = 1'b1;
      cen_n = 1'b1;
      @(posedge clk);
      #1;
      irq_bus.INTACK = 1'b0;
   endtask

   task automatic line_sweep(input logic [8:0] v, input bit do_skip,
                             output int hs_cnt, output int hs_first, output int hb_lo);
      hs_cnt   = 0;
      hs_first = -1;
      hb_lo    = 0;
      for (int h = 128; h < 512; h++) begin
         if (do_skip && h > 221 && h < 228) continue;
         tick(h[8:0], v);
         if (hsync_n == 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = h;
         end
         if (hblank_n == 1'b0) hb_lo++;
      end
   endtask

   int hs_cnt, hs_first, hb_lo;
   int vs_lines, vb_lines, vb_first;

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      cen_n = 1'b0;
      h_cnt = 9'd300;
      v_cnt = 9'd300;
      irq_bus.IRQ_EN = 1'b0;
      irq_bus.INTACK = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hsync",  {31'd0, hsync_n},  32'd1);
      chk("rst_vsync",  {31'd0, vsync_n},  32'd1);
      chk("rst_hblank", {31'd0, hblank_n}, 32'd0);
      chk("rst_vblank", {31'd0, vblank_n}, 32'd0);
      chk("rst_irq_n",  {31'd0, irq_bus.IRQ_n}, 32'd1);
      chk("rst_vector", {24'd0, irq_bus.IRQ_VECTOR}, 32'hFF);
      rst = 1'b0;
      cen_n = 1'b1;

      // Full line, then one with H 222..227 skipped
      line_sweep(9'd300, 1'b0, hs_cnt, hs_first, hb_lo);
      chk("hs_width",   hs_cnt,   32'd32);
      chk("hs_first",   hs_first, 32'd292);
      chk("hb_lo_cnt",  hb_lo,    32'd128);
      chk("vblank_act", {31'd0, vblank_n}, 32'd1);
      tick(9'd128, 9'd301);
      chk("hb_fall_128", {31'd0, hblank_n}, 32'd0);
      tick(9'd255, 9'd301);
      chk("hb_255", {31'd0, hblank_n}, 32'd0);
      tick(9'd256, 9'd301);
      chk("hb_rise_256", {31'd0, hblank_n}, 32'd1);

      line_sweep(9'd302, 1'b1, hs_cnt, hs_first, hb_lo);
      chk("skip_hs_width", hs_cnt,   32'd32);
      chk("skip_hs_first", hs_first, 32'd292);
      chk("skip_hb_lo",    hb_lo,    32'd122);

      // Vertical sweep of a whole frame, one sample per line
      vs_lines = 0;
      vb_lines = 0;
      vb_first = -1;
      for (int v = 220; v < 512; v++) begin
         tick(9'd200, v[8:0]);
         if (vsync_n == 1'b0) vs_lines++;
         if (vblank_n == 1'b1) begin
            vb_lines++;
            if (vb_first < 0) vb_first = v;
         end
      end
      chk("vs_lines",  vs_lines, 32'd4);
      chk("vb_lines",  vb_lines, 32'd224);
      chk("vb_first",  vb_first, 32'd272);
      tick(9'd200, 9'd220);
      chk("v_wrap_vblank", {31'd0, vblank_n}, 32'd0);
      chk("no_irq_when_dis", {31'd0, irq_bus.IRQ_n}, 32'd1);

      // LINE interrupt and acknowledge
      irq_bus.IRQ_EN = 1'b1;
      tick(9'd128, 9'd272);
      chk("line_irq_n",  {31'd0, irq_bus.IRQ_n}, 32'd0);
      chk("line_vector", {24'd0, irq_bus.IRQ_VECTOR}, 32'hCF);
      ack();
      chk("ack_irq_n",  {31'd0, irq_bus.IRQ_n}, 32'd1);
      chk("ack_vector", {24'd0, irq_bus.IRQ_VECTOR}, 32'hFF);
      ack();
      chk("ack_empty", {24'd0, irq_bus.IRQ_VECTOR}, 32'hFF);

      // LINE left pending, VBL arrives and takes priority
      tick(9'd128, 9'd272);
      tick(9'd129, 9'd272);
      tick(9'd128, 9'd400);
      chk("line_hold", {24'd0, irq_bus.IRQ_VECTOR}, 32'hCF);
      tick(9'd128, 9'd496);
      chk("vbl_vector", {24'd0, irq_bus.IRQ_VECTOR}, 32'hD7);
      chk("vbl_irq_n",  {31'd0, irq_bus.IRQ_n}, 32'd0);
      ack();
      chk("ack1_vector", {24'd0, irq_bus.IRQ_VECTOR}, 32'hCF);
      chk("ack1_irq_n",  {31'd0, irq_bus.IRQ_n}, 32'd0);
      ack();
      chk("ack2_irq_n",  {31'd0, irq_bus.IRQ_n}, 32'd1);

      // Set and clear of the same source on one edge: set wins
      tick(9'd128, 9'd272);
      irq_bus.INTACK = 1'b1;
      tick(9'd128, 9'd272);
      irq_bus.INTACK = 1'b0;
      chk("set_wins_irq_n", {31'd0, irq_bus.IRQ_n}, 32'd0);
      chk("set_wins_vec",   {24'd0, irq_bus.IRQ_VECTOR}, 32'hCF);

      // Enable held off: pending holds, acknowledge still clears, events ignored
      tick(9'd300, 9'd300);
      h_cnt = 9'd128;
      v_cnt = 9'd272;
      idle_mclk(4);
      chk("gate_hsync", {31'd0, hsync_n}, 32'd0);
      chk("gate_pend",  {31'd0, irq_bus.IRQ_n}, 32'd0);
      ack();
      idle_mclk(3);
      chk("gate_ack_irq_n", {31'd0, irq_bus.IRQ_n}, 32'd1);

      // Both pending, then enable dropped
      tick(9'd128, 9'd272);
      tick(9'd128, 9'd496);
      chk("both_vec", {24'd0, irq_bus.IRQ_VECTOR}, 32'hD7);
      irq_bus.IRQ_EN = 1'b0;
      idle_mclk(1);
      chk("dis_irq_n",  {31'd0, irq_bus.IRQ_n}, 32'd1);
      chk("dis_vector", {24'd0, irq_bus.IRQ_VECTOR}, 32'hFF);
      tick(9'd128, 9'd272);
      chk("dis_ignore", {31'd0, irq_bus.IRQ_n}, 32'd1);

      // Reset mid-line
      tick(9'd300, 9'd300);
      rst = 1'b1;
      cen_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_hblank", {31'd0, hblank_n}, 32'd0);
      chk("midrst_vblank", {31'd0, vblank_n}, 32'd0);
      chk("midrst_hsync",  {31'd0, hsync_n},  32'd1);
      rst = 1'b0;
      tick(9'd300, 9'd300);
      chk("post_rst_hblank", {31'd0, hblank_n}, 32'd1);
      chk("post_rst_hsync",  {31'd0, hsync_n},  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
